fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode-stage control logic. Owns the program counter, drives a variable-latency instruction-memory request/ready interface and loads the IF/ID pipeline register that supplies `InstrD` (op/Funct fields) and `PCPlus4D` to decode. Honours decode stalls from the hazard unit and redirects on taken branches (`PCSrcD`/`PCBranchD`) resolved in decode, squashing wrong-path words, including a response still in flight.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 31 +++
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline types and constants for the five-stage MIPS core.
package mips_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned IF_ID_W = 2 * XLEN;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN,
      HOLD,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pcPlus4;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic stage register: data + valid, hold on !en, synchronous clear-to-bubble.
module if_id_reg
   import mips_pkg::*;
#(
   parameter int unsigned  W       = IF_ID_W,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   input  logic         validIn,
   output logic [W-1:0] q,
   output logic         validOut
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q        <= '0;
         validOut <= 1'b0;
      end else if (clr) begin
         q        <= CLR_VAL;
         validOut <= 1'b0;
      end else if (en) begin
         q        <= d;
         validOut <= validIn;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PCF, drives the variable-latency imem interface
// and loads the IF/ID register; handles decode stalls and branch redirects.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            StallD,
   input  logic            PCSrcD,
   input  logic [XLEN-1:0] PCBranchD,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
);

   fetch_state_t    state;
   logic [XLEN-1:0] pcF;
   logic [XLEN-1:0] redirPc;
   logic [XLEN-1:0] bufInstr;
   logic            running;

   logic [XLEN-1:0] pcPlus4F;
   logic [XLEN-1:0] branchTarget;
   logic            redirect;

   logic            ifIdEn;
   logic            ifIdClr;
   if_id_t          ifIdD;
   if_id_t          ifIdQ;

   assign pcPlus4F     = pcF + XLEN'(4);
   assign branchTarget = PCBranchD & ~XLEN'(3);
   assign redirect     = PCSrcD && !StallD;

   // running gates the first post-reset cycle so imem_req stays low there
   assign imem_req  = running && (state != HOLD);
   assign imem_addr = pcF;

   // IF/ID load / bubble selection
   always_comb begin
      ifIdEn        = 1'b0;
      ifIdClr       = 1'b0;
      ifIdD.instr   = imem_rdata;
      ifIdD.pcPlus4 = pcPlus4F;
      if (running && !StallD) begin
         case (state)
            RUN: begin
               if (redirect || !imem_ready) ifIdClr = 1'b1;
               else                         ifIdEn  = 1'b1;
            end
            HOLD: begin
               if (redirect) begin
                  ifIdClr = 1'b1;
               end else begin
                  ifIdEn      = 1'b1;
                  ifIdD.instr = bufInstr;
               end
            end
            default: ifIdClr = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         pcF      <= RESET_PC;
         redirPc  <= '0;
         bufInstr <= '0;
         running  <= 1'b0;
      end else if (!running) begin
         running <= 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (StallD) begin
                  if (imem_ready) begin
                     bufInstr <= imem_rdata;
                     state    <= HOLD;
                  end
               end else if (PCSrcD) begin
                  if (imem_ready) begin
                     pcF <= branchTarget;
                  end else begin
                     redirPc <= branchTarget;
                     state   <= DROP;
                  end
               end else if (imem_ready) begin
                  pcF <= pcPlus4F;
               end
            end
            HOLD: begin
               if (!StallD) begin
                  pcF   <= PCSrcD ? branchTarget : pcPlus4F;
                  state <= RUN;
               end
            end
            DROP: begin
               // address held until the stale word returns; latest redirect wins
               if (imem_ready) begin
                  pcF   <= redirect ? branchTarget : redirPc;
                  state <= RUN;
               end else if (redirect) begin
                  redirPc <= branchTarget;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   if_id_reg #(
      .W       (IF_ID_W),
      .CLR_VAL (IF_ID_W'({NOP_INSTR, XLEN'(0)}))
   ) uIfId (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (ifIdEn),
      .clr      (ifIdClr),
      .d        (ifIdD),
      .validIn  (1'b1),
      .q        (ifIdQ),
      .validOut (ValidD)
   );

   assign InstrD   = ifIdQ.instr;
   assign PCPlus4D = ifIdQ.pcPlus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, slow-memory redirect and reset
// sequences, then randomized traffic against an instruction-stream model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        StallD;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic        imem_ready2;
   logic [31:0] imem_rdata2;
   logic [31:0] InstrD2;
   logic [31:0] PCPlus4D2;
   logic        ValidD2;

   int          nChecks = 0;
   int          nPass   = 0;

   // memory model state
   int          memLat;
   int          remain;
   bit          pending;
   logic [31:0] pendAddr;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .StallD     (StallD),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .InstrD     (InstrD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
      .clk        (clk),
      .rst_n      (rst_n),
      .StallD     (StallD),
      .PCSrcD     (PCSrcD),
      .PCBranchD  (PCBranchD),
      .imem_req   (imem_req2),
      .imem_addr  (imem_addr2),
      .imem_ready (imem_ready2),
      .imem_rdata (imem_rdata2),
      .InstrD     (InstrD2),
      .PCPlus4D   (PCPlus4D2),
      .ValidD     (ValidD2)
   );

   assign imem_ready2 = imem_req2;
   assign imem_rdata2 = imem_addr2 + 32'h100;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // memory: mem[a] = a + 0x100; memLat wait states (-1 = random 0..3)
   task automatic memDrive();
      if (imem_req !== 1'b1) begin
         pending    = 1'b0;
         imem_ready = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
      end else begin
         if (!pending) begin
            pending  = 1'b1;
            pendAddr = imem_addr;
            remain   = (memLat < 0) ? int'($urandom_range(0, 3)) : memLat;
         end else begin
            chk("addr_stable", imem_addr, pendAddr);
         end
         imem_ready = (remain == 0);
         imem_rdata = (remain == 0) ? imem_addr + 32'h100 : 32'hDEAD_BEEF;
         if (remain == 0) pending = 1'b0;
         else             remain--;
      end
   endtask

   task automatic step();
      @(negedge clk);
      memDrive();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst_n     = 1'b0;
      StallD    = 1'b0;
      PCSrcD    = 1'b0;
      PCBranchD = '0;
      step();
      step();
      chk("rst_req",   32'(imem_req), 32'h0);
      chk("rst_addr",  imem_addr,     32'h0);
      chk("rst_instr", InstrD,        32'h0);
      chk("rst_pc4",   PCPlus4D,      32'h0);
      chk("rst_valid", 32'(ValidD),   32'h0);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        stall;
      logic        pcsrc;
      logic [31:0] target;
      logic        expReq;
      logic [31:0] expAddr;
      logic [31:0] expInstr;
      logic [31:0] expPc4;
      logic        expValid;
   } vec_t;

   vec_t        vec[14];
   logic [31:0] wrapAddr[3];
   logic [31:0] nextPc;
   logic [31:0] pI, pP;
   logic        pV;
   logic        st, rd;
   logic [31:0] tg;
   int          waited;
   int          nValid;

   initial begin
      // first row: the cycle right after reset release (no request yet)
      vec[0]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h00, 32'h000, 32'h00, 1'b0};
      vec[1]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h04, 32'h100, 32'h04, 1'b1};
      vec[2]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h08, 32'h104, 32'h08, 1'b1};
      vec[3]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h0C, 32'h108, 32'h0C, 1'b1};
      vec[4]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h10, 32'h10C, 32'h10, 1'b1};
      vec[5]  = '{1'b0, 1'b1, 32'h043, 1'b1, 32'h40, 32'h000, 32'h00, 1'b0};
      vec[6]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h44, 32'h140, 32'h44, 1'b1};
      vec[7]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h44, 32'h140, 32'h44, 1'b1};
      vec[8]  = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h44, 32'h140, 32'h44, 1'b1};
      vec[9]  = '{1'b1, 1'b0, 32'h000, 1'b0, 32'h44, 32'h140, 32'h44, 1'b1};
      vec[10] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h48, 32'h144, 32'h48, 1'b1};
      vec[11] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h4C, 32'h148, 32'h4C, 1'b1};
      vec[12] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h4C, 32'h148, 32'h4C, 1'b1};
      vec[13] = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h50, 32'h14C, 32'h50, 1'b1};
      wrapAddr[0] = 32'hFFFF_FFF8;
      wrapAddr[1] = 32'hFFFF_FFFC;
      wrapAddr[2] = 32'h0000_0000;

      pending    = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = '0;
      memLat     = 0;

      // zero-wait stream, branch, stall/hold
      resetDut();
      for (int k = 0; k < 14; k++) begin
         StallD    = vec[k].stall;
         PCSrcD    = vec[k].pcsrc;
         PCBranchD = vec[k].target;
         step();
         chk($sformatf("v%0d_req", k),   32'(imem_req), 32'(vec[k].expReq));
         chk($sformatf("v%0d_addr", k),  imem_addr,     vec[k].expAddr);
         chk($sformatf("v%0d_instr", k), InstrD,        vec[k].expInstr);
         chk($sformatf("v%0d_valid", k), 32'(ValidD),   32'(vec[k].expValid));
         if (vec[k].expValid) chk($sformatf("v%0d_pc4", k), PCPlus4D, vec[k].expPc4);
         if (k < 3) chk($sformatf("wrap%0d_addr", k), imem_addr2, wrapAddr[k]);
         if (k == 1) begin
            chk("wrap_instr", InstrD2,       32'h0000_00F8);
            chk("wrap_pc4",   PCPlus4D2,     32'hFFFF_FFFC);
            chk("wrap_valid", 32'(ValidD2),  32'h1);
         end
         if (k == 2) chk("wrap_pc4_0", PCPlus4D2, 32'h0);
      end
      StallD = 1'b0;
      PCSrcD = 1'b0;

      // redirect to 0x80 behind a slow request at 0x20
      resetDut();
      memLat = 0;
      for (int i = 0; i < 20 && imem_addr != 32'h20; i++) step();
      chk("reach_20", imem_addr, 32'h20);
      memLat = 3;
      step();
      PCSrcD    = 1'b1;
      PCBranchD = 32'h80;
      step();
      PCSrcD = 1'b0;
      chk("drop_req",   32'(imem_req), 32'h1);
      chk("drop_addr",  imem_addr,     32'h20);
      chk("drop_valid", 32'(ValidD),   32'h0);
      waited = 0;
      while (imem_addr == 32'h20 && waited < 10) begin
         chk("drop_bubble", 32'(ValidD), 32'h0);
         step();
         waited++;
      end
      chk("drop_wait",  32'(waited),   32'd2);
      chk("redir_addr", imem_addr,     32'h80);
      chk("redir_bub",  32'(ValidD),   32'h0);
      waited = 0;
      while (!ValidD && waited < 10) begin
         step();
         waited++;
      end
      chk("tgt_valid", 32'(ValidD), 32'h1);
      chk("tgt_instr", InstrD,      32'h180);
      chk("tgt_pc4",   PCPlus4D,    32'h84);

      // reset while a redirect is pending
      PCSrcD    = 1'b1;
      PCBranchD = 32'h100;
      step();
      PCSrcD = 1'b0;
      chk("drop2_req",  32'(imem_req), 32'h1);
      chk("drop2_addr", imem_addr,     32'h84);
      rst_n = 1'b0;
      step();
      chk("mrst_req",   32'(imem_req), 32'h0);
      chk("mrst_addr",  imem_addr,     32'h0);
      chk("mrst_instr", InstrD,        32'h0);
      chk("mrst_pc4",   PCPlus4D,      32'h0);
      chk("mrst_valid", 32'(ValidD),   32'h0);

      // randomized traffic against the architectural instruction stream
      resetDut();
      memLat = -1;
      nextPc = 32'h0;
      nValid = 0;
      for (int c = 0; c < 3000; c++) begin
         st = (c >= 2) && ($urandom_range(0, 3) == 0);
         rd = (c >= 2) && ($urandom_range(0, 9) == 0);
         tg = $urandom & 32'h0000_0FFF;
         StallD    = st;
         PCSrcD    = rd;
         PCBranchD = tg;
         pI = InstrD;
         pP = PCPlus4D;
         pV = ValidD;
         step();
         if (st) begin
            chk("rnd_hold_instr", InstrD,      pI);
            chk("rnd_hold_pc4",   PCPlus4D,    pP);
            chk("rnd_hold_valid", 32'(ValidD), 32'(pV));
         end else if (rd) begin
            chk("rnd_br_valid", 32'(ValidD), 32'h0);
            chk("rnd_br_instr", InstrD,      32'h0);
            nextPc = tg & ~32'h3;
         end else if (ValidD) begin
            chk("rnd_instr", InstrD,   nextPc + 32'h100);
            chk("rnd_pc4",   PCPlus4D, nextPc + 32'h4);
            nextPc = nextPc + 32'h4;
            nValid++;
         end else begin
            chk("rnd_bubble", InstrD, 32'h0);
         end
      end
      chk("rnd_progress", 32'(nValid > 200), 32'h1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
